// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types, encodings and decode helpers for the multi-cycle control unit
package multicycle_pkg;

    typedef enum logic [4:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLINK,
        S_TRAP
    } state_t;

    // ALU operation codes, cast to the configured ALUControl width at use
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLT  = 5;
    localparam int ALU_SLTU = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:        return IMM_S;
            OP_BRANCH:       return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:          return IMM_J;
            default:         return IMM_I;
        endcase
    endfunction

    // Reserved funct3/funct7 combinations within otherwise supported opcodes
    function automatic logic encoding_legal(input logic [6:0] op,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5);
        case (op)
            OP_BRANCH: return !(funct3 == 3'b010 || funct3 == 3'b011);
            OP_LOAD:   return !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
            OP_STORE:  return funct3 <= 3'b010;
            OP_JALR:   return funct3 == 3'b000;
            OP_RTYPE:  return !funct7b5 || funct3 == 3'b000 || funct3 == 3'b101;
            OP_ITYPE:  return !(funct3 == 3'b001 && funct7b5);
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7b5 to ALUControl mapping for register and immediate ALU ops
module alu_decoder
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_WIDTH = 4
) (
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     is_rtype,
    output logic [ALUCTRL_WIDTH-1:0] alu_control
);

    // SUB exists only in register form; SRA is selected by bit 30 in both forms
    always_comb begin
        alu_control = ALUCTRL_WIDTH'(ALU_ADD);
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALUCTRL_WIDTH'(ALU_SUB)
                                                          : ALUCTRL_WIDTH'(ALU_ADD);
            3'b001:  alu_control = ALUCTRL_WIDTH'(ALU_SLL);
            3'b010:  alu_control = ALUCTRL_WIDTH'(ALU_SLT);
            3'b011:  alu_control = ALUCTRL_WIDTH'(ALU_SLTU);
            3'b100:  alu_control = ALUCTRL_WIDTH'(ALU_XOR);
            3'b101:  alu_control = funct7b5 ? ALUCTRL_WIDTH'(ALU_SRA)
                                            : ALUCTRL_WIDTH'(ALU_SRL);
            3'b110:  alu_control = ALUCTRL_WIDTH'(ALU_OR);
            default: alu_control = ALUCTRL_WIDTH'(ALU_AND);
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle sequencer with memory handshake and trapping
module multicycle_control_unit
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_WIDTH = 4,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     Zero,
    input  logic                     Lt,
    input  logic                     Ltu,
    input  logic                     MemReady,
    output logic                     MemReq,
    output logic                     MemWrite,
    output logic [2:0]               MemSize,
    output logic                     AdrSrc,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     PCMaskLsb,
    output logic                     RegWrite,
    output logic [2:0]               ImmSrc,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [ALUCTRL_WIDTH-1:0] ALUControl,
    output logic [1:0]               ResultSrc,
    output logic                     InstrRetired,
    output logic                     Trap,
    output logic [1:0]               TrapCause
);

    // Wait counter runs 0..MEM_TIMEOUT-1; the last value is the final cycle MemReady may arrive
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t                   state;
    state_t                   next_state;
    logic [CNT_W-1:0]         wait_cnt;
    logic [1:0]               cause_q;
    logic [1:0]               next_cause;
    logic                     expired;
    logic                     mem_wait;
    logic                     taken;
    logic [ALUCTRL_WIDTH-1:0] dec_ctrl;

    alu_decoder #(
        .ALUCTRL_WIDTH(ALUCTRL_WIDTH)
    ) u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (state == S_EXECR),
        .alu_control (dec_ctrl)
    );

    assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign expired  = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_LAST);

    // Branch condition from the comparator flags; reserved funct3 never reaches BRANCH
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = !Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = !Ltu;
            default: taken = 1'b0;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter restarts on every state change and counts cycles spent stalled on memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (mem_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Trap cause is captured on entry to TRAP and kept until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= CAUSE_NONE;
        end else begin
            cause_q <= next_cause;
        end
    end

    // Next-state and control outputs
    always_comb begin
        next_state   = state;
        next_cause   = cause_q;
        MemReq       = 1'b0;
        MemWrite     = 1'b0;
        MemSize      = 3'b000;
        AdrSrc       = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCMaskLsb    = 1'b0;
        RegWrite     = 1'b0;
        ImmSrc       = imm_src_for(op);
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_B;
        ALUControl   = ALUCTRL_WIDTH'(ALU_ADD);
        ResultSrc    = RES_ALUOUT;
        InstrRetired = 1'b0;
        Trap         = 1'b0;
        TrapCause    = CAUSE_NONE;

        case (state)
            S_BOOT: begin
                ImmSrc     = 3'b000;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (!encoding_legal(op, funct3, funct7b5)) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_RTYPE:          next_state = S_EXECR;
                        OP_ITYPE:          next_state = S_EXECI;
                        OP_LUI:            next_state = S_LUI;
                        OP_AUIPC:          next_state = S_AUIPC;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALR;
                        default: begin
                            next_state = S_TRAP;
                            next_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemReq  = 1'b1;
                AdrSrc  = 1'b1;
                MemSize = funct3;
                if (MemReady) begin
                    next_state = S_MEMWB;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                MemSize  = funct3;
                if (MemReady) begin
                    InstrRetired = 1'b1;
                    next_state   = S_FETCH;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                next_state   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = dec_ctrl;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_ctrl;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc    = RES_ALUOUT;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                next_state   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_B;
                ALUControl   = ALUCTRL_WIDTH'(ALU_SUB);
                ResultSrc    = RES_ALUOUT;
                PCWrite      = taken;
                InstrRetired = 1'b1;
                next_state   = S_FETCH;
            end
            S_JAL: begin
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                next_state = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURESULT;
                PCWrite    = 1'b1;
                PCMaskLsb  = 1'b1;
                next_state = S_JALRLINK;
            end
            S_JALRLINK: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                ImmSrc    = 3'b000;
                Trap      = 1'b1;
                TrapCause = cause_q;
            end
            default: begin
                next_state = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Lt;
    logic       Ltu;
    logic       MemReady;
    logic       MemReq;
    logic       MemWrite;
    logic [2:0] MemSize;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCMaskLsb;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [1:0] ResultSrc;
    logic       InstrRetired;
    logic       Trap;
    logic [1:0] TrapCause;

    int checks = 0;
    int errors = 0;

    wire [26:0] all_outs = {MemReq, MemWrite, MemSize, AdrSrc, IRWrite, PCWrite, PCMaskLsb,
                            RegWrite, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
                            InstrRetired, Trap, TrapCause};

    multicycle_control_unit #(
        .ALUCTRL_WIDTH(4),
        .MEM_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .Lt           (Lt),
        .Ltu          (Ltu),
        .MemReady     (MemReady),
        .MemReq       (MemReq),
        .MemWrite     (MemWrite),
        .MemSize      (MemSize),
        .AdrSrc       (AdrSrc),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCMaskLsb    (PCMaskLsb),
        .RegWrite     (RegWrite),
        .ImmSrc       (ImmSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ResultSrc    (ResultSrc),
        .InstrRetired (InstrRetired),
        .Trap         (Trap),
        .TrapCause    (TrapCause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instruction fetch with MemReady on the first cycle; leaves the FSM in DECODE
    task automatic fetch_now(input logic [6:0] o, input logic [2:0] f3, input logic b5);
        op = o; funct3 = f3; funct7b5 = b5; MemReady = 1'b1;
        #1;
        tick();
        MemReady = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; MemReady = 1'b0;
        #12;
        chk("boot_all_zero", 32'(all_outs), 0);
        rst_n = 1'b1;
        tick();

        // addi: FETCH, DECODE, EXECI, ALUWB
        op = 7'b0010011; funct3 = 3'b000; MemReady = 1'b1;
        #1;
        chk("addi_fetch_memreq", 32'(MemReq), 1);
        chk("addi_fetch_irwrite", 32'(IRWrite), 1);
        chk("addi_fetch_pcwrite", 32'(PCWrite), 1);
        chk("addi_fetch_srcb", 32'(ALUSrcB), 2);
        chk("addi_fetch_result", 32'(ResultSrc), 2);
        tick(); MemReady = 1'b0; #1;
        chk("addi_decode_srca", 32'(ALUSrcA), 1);
        chk("addi_decode_srcb", 32'(ALUSrcB), 1);
        chk("addi_decode_irwrite", 32'(IRWrite), 0);
        tick(); #1;
        chk("addi_execi_aluctrl", 32'(ALUControl), 0);
        chk("addi_execi_srcb", 32'(ALUSrcB), 1);
        chk("addi_execi_srca", 32'(ALUSrcA), 2);
        chk("addi_execi_retired", 32'(InstrRetired), 0);
        tick(); #1;
        chk("addi_aluwb_regwrite", 32'(RegWrite), 1);
        chk("addi_aluwb_retired", 32'(InstrRetired), 1);
        chk("addi_aluwb_result", 32'(ResultSrc), 0);
        tick();

        // lw with three stall cycles in FETCH and in MEMREAD
        op = 7'b0000011; funct3 = 3'b010; MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_fetch_wait_memreq", 32'(MemReq), 1);
            chk("lw_fetch_wait_irwrite", 32'(IRWrite), 0);
            tick();
        end
        MemReady = 1'b1; #1;
        chk("lw_fetch_ready_irwrite", 32'(IRWrite), 1);
        tick(); MemReady = 1'b0; #1;
        chk("lw_decode_immsrc", 32'(ImmSrc), 0);
        tick(); #1;
        chk("lw_memadr_srca", 32'(ALUSrcA), 2);
        chk("lw_memadr_srcb", 32'(ALUSrcB), 1);
        chk("lw_memadr_memreq", 32'(MemReq), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_memread_memreq", 32'(MemReq), 1);
            chk("lw_memread_adrsrc", 32'(AdrSrc), 1);
            chk("lw_memread_memsize", 32'(MemSize), 2);
            chk("lw_memread_memwrite", 32'(MemWrite), 0);
            tick();
        end
        MemReady = 1'b1; #1;
        chk("lw_memread_ready_retired", 32'(InstrRetired), 0);
        tick(); MemReady = 1'b0; #1;
        chk("lw_memwb_result", 32'(ResultSrc), 1);
        chk("lw_memwb_regwrite", 32'(RegWrite), 1);
        chk("lw_memwb_retired", 32'(InstrRetired), 1);
        chk("lw_memwb_memsize", 32'(MemSize), 0);
        tick();

        // bne taken then not taken
        fetch_now(7'b1100011, 3'b001, 1'b0); #1;
        chk("bne_decode_immsrc", 32'(ImmSrc), 2);
        tick(); Zero = 1'b0; #1;
        chk("bne_taken_pcwrite", 32'(PCWrite), 1);
        chk("bne_taken_aluctrl", 32'(ALUControl), 1);
        chk("bne_taken_retired", 32'(InstrRetired), 1);
        tick();
        fetch_now(7'b1100011, 3'b001, 1'b0);
        tick(); Zero = 1'b1; #1;
        chk("bne_nottaken_pcwrite", 32'(PCWrite), 0);
        chk("bne_nottaken_retired", 32'(InstrRetired), 1);
        tick(); Zero = 1'b0;

        // bltu taken on Ltu
        fetch_now(7'b1100011, 3'b110, 1'b0);
        tick(); Ltu = 1'b1; #1;
        chk("bltu_taken_pcwrite", 32'(PCWrite), 1);
        tick(); Ltu = 1'b0;

        // jalr: JALR, JALRLINK, ALUWB
        fetch_now(7'b1100111, 3'b000, 1'b0);
        tick(); #1;
        chk("jalr_pcwrite", 32'(PCWrite), 1);
        chk("jalr_masklsb", 32'(PCMaskLsb), 1);
        chk("jalr_result", 32'(ResultSrc), 2);
        chk("jalr_srca", 32'(ALUSrcA), 2);
        tick(); #1;
        chk("jalrlink_srca", 32'(ALUSrcA), 1);
        chk("jalrlink_srcb", 32'(ALUSrcB), 2);
        chk("jalrlink_pcwrite", 32'(PCWrite), 0);
        tick(); #1;
        chk("jalr_aluwb_regwrite", 32'(RegWrite), 1);
        chk("jalr_aluwb_retired", 32'(InstrRetired), 1);
        tick();

        // sub in register form, srai in immediate form
        fetch_now(7'b0110011, 3'b000, 1'b1);
        tick(); #1;
        chk("sub_execr_aluctrl", 32'(ALUControl), 1);
        chk("sub_execr_srcb", 32'(ALUSrcB), 0);
        tick(); tick();
        fetch_now(7'b0010011, 3'b101, 1'b1);
        tick(); #1;
        chk("srai_execi_aluctrl", 32'(ALUControl), 9);
        tick(); tick();

        // sw completing on the first MEMWRITE cycle
        fetch_now(7'b0100011, 3'b010, 1'b0); #1;
        chk("sw_decode_immsrc", 32'(ImmSrc), 1);
        tick(); tick(); MemReady = 1'b1; #1;
        chk("sw_memwrite_memwrite", 32'(MemWrite), 1);
        chk("sw_memwrite_memreq", 32'(MemReq), 1);
        chk("sw_memwrite_retired", 32'(InstrRetired), 1);
        chk("sw_memwrite_memsize", 32'(MemSize), 2);
        tick(); MemReady = 1'b0;

        // MemReady on the sixteenth FETCH cycle still completes
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        MemReady = 1'b1; #1;
        chk("edge_ready_irwrite", 32'(IRWrite), 1);
        tick(); MemReady = 1'b0; #1;
        chk("edge_ready_no_trap", 32'(Trap), 0);
        chk("edge_ready_decode_srca", 32'(ALUSrcA), 1);
        tick(); tick(); tick();

        // Illegal opcode traps and stays trapped, ignoring MemReady
        fetch_now(7'b0000000, 3'b000, 1'b0);
        tick();
        MemReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("illegal_trap", 32'(Trap), 1);
            chk("illegal_cause", 32'(TrapCause), 1);
            chk("illegal_memreq", 32'(MemReq), 0);
            tick();
        end
        rst_n = 1'b0; #1;
        chk("reset_from_trap_all_zero", 32'(all_outs), 0);
        MemReady = 1'b0; #1;
        rst_n = 1'b1;
        tick();

        // FETCH timeout after sixteen stalled cycles
        op = 7'b0010011;
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("timeout_cycle16_no_trap", 32'(Trap), 0);
        chk("timeout_cycle16_memreq", 32'(MemReq), 1);
        tick(); #1;
        chk("timeout_trap", 32'(Trap), 1);
        chk("timeout_cause", 32'(TrapCause), 2);
        chk("timeout_memreq", 32'(MemReq), 0);

        // Reserved store width traps as illegal
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        fetch_now(7'b0100011, 3'b011, 1'b0);
        tick(); #1;
        chk("bad_store_trap", 32'(Trap), 1);
        chk("bad_store_cause", 32'(TrapCause), 1);

        // SLLI with bit 30 set traps as illegal
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        fetch_now(7'b0010011, 3'b001, 1'b1);
        tick(); #1;
        chk("bad_slli_cause", 32'(TrapCause), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
